// File: rtl/adc_sum_sq_pkg.sv
// Shared types, default widths and the saturating adder for the ADC power
// (sum-of-squares) measurement block.
package adc_sum_sq_pkg;

  localparam int DEF_ADC_W   = 8;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_LEN_MAX = 24;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    ACCUM
  } state_e;

  // Operands are at most 32 bits wide, so the 64-bit sum cannot wrap before the clamp.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max_val);
    logic [63:0] s;
    s = a + b;
    return (s > max_val) ? max_val : s;
  endfunction

endpackage

// File: rtl/adc_sum_sq_ctrl_sum_sq_accum.sv
// Two-stage square-and-accumulate datapath: stage 1 registers the exact square,
// stage 2 accumulates with saturation and publishes on the window's last sample.
module sum_sq_accum
  import adc_sum_sq_pkg::*;
#(
  parameter int ADC_W = DEF_ADC_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [ADC_W-1:0] adc_data_i,
  input  logic                    smp_vld_i,
  input  logic                    smp_last_i,
  input  logic                    flush_i,
  input  logic                    clr_sat_i,
  output logic [ACC_W-1:0]        sum_o,
  output logic                    sum_vld_o,
  output logic [CNT_W-1:0]        win_cnt_o,
  output logic                    sat_o,
  output logic                    vld_p1_o
);

  localparam int SQ_W = 2 * ADC_W - 1;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  logic signed [SQ_W-1:0] adc_ext;
  logic [SQ_W-1:0]        sq_d;
  logic [SQ_W-1:0]        sq_p1_q;
  logic                   vld_p1_q;
  logic                   last_p1_q;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_vld_q, sum_vld_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             sat_q, sat_d;
  logic [63:0]      add_full;
  logic             sat_hit;

  // Squaring in 2*ADC_W-1 bits keeps (-2^(ADC_W-1))^2 exact as an unsigned value.
  assign adc_ext = SQ_W'(adc_data_i);
  assign sq_d    = adc_ext * adc_ext;

  // ---- stage 1: registered square ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else if (flush_i) begin
      sq_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      sq_p1_q   <= sq_d;
      vld_p1_q  <= smp_vld_i;
      last_p1_q <= smp_vld_i & smp_last_i;
    end
  end

  // ---- stage 2: saturating accumulate and publish ----
  // Once clamped the running sum stays pinned at full scale, so a full-scale
  // result is exactly the saturated-window condition.
  assign add_full = sat_add(64'(acc_q), 64'(sq_p1_q), ACC_MAX);
  assign sat_hit  = (add_full == ACC_MAX);

  always_comb begin
    acc_d     = acc_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    win_cnt_d = win_cnt_q;
    sat_d     = sat_q & ~clr_sat_i;
    if (flush_i) begin
      acc_d = '0;
    end else if (vld_p1_q) begin
      if (last_p1_q) begin
        sum_d     = add_full[ACC_W-1:0];
        sum_vld_d = 1'b1;
        win_cnt_d = win_cnt_q + CNT_W'(1);
        acc_d     = '0;
        sat_d     = sat_d | sat_hit;
      end else begin
        acc_d = add_full[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      win_cnt_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      win_cnt_q <= win_cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign sum_o     = sum_q;
  assign sum_vld_o = sum_vld_q;
  assign win_cnt_o = win_cnt_q;
  assign sat_o     = sat_q;
  assign vld_p1_o  = vld_p1_q;

endmodule

// File: rtl/adc_sum_sq_ctrl.sv
// ADC power measurement sequencer: arm/sync window control, 2^L sample windows,
// single-shot or gapless continuous operation, feeding the sum_sq_accum datapath.
module adc_sum_sq_ctrl
  import adc_sum_sq_pkg::*;
#(
  parameter int ADC_W   = DEF_ADC_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int LEN_MAX = DEF_LEN_MAX,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    sync_in,
  input  logic                    ctrl_en,
  input  logic                    ctrl_arm,
  input  logic                    ctrl_cont,
  input  logic [4:0]              ctrl_len_log2,
  output logic [ACC_W-1:0]        sum_sq_out,
  output logic                    sum_sq_valid,
  output logic [CNT_W-1:0]        win_cnt,
  output logic                    sat_flag,
  output logic                    busy
);

  localparam int CW = LEN_MAX + 1;

  state_e         state_q, state_d;
  logic           arm_q;
  logic [4:0]     len_q, len_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [4:0]     len_req;
  logic [4:0]     len_eff;
  logic [CW-1:0]  cnt_eff;
  logic [CW-1:0]  term;
  logic           in_wait;
  logic           arm_evt;
  logic           accept;
  logic           smp_last;
  logic           clr_sat;
  logic           vld_p1;

  assign arm_evt = ctrl_arm & ~arm_q;
  assign len_req = (ctrl_len_log2 > 5'(LEN_MAX)) ? 5'(LEN_MAX) : ctrl_len_log2;
  assign in_wait = (state_q == WAIT_SYNC);

  // The sync cycle's own sample opens the window, so it sees a fresh count and
  // the live length request rather than the registered ones.
  assign len_eff  = in_wait ? len_req : len_q;
  assign cnt_eff  = in_wait ? '0 : cnt_q;
  assign term     = CW'(1) << len_eff;
  assign accept   = ctrl_en & adc_valid & ((state_q == ACCUM) | (in_wait & sync_in));
  assign smp_last = accept & ((cnt_eff + CW'(1)) == term);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= ctrl_arm;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    clr_sat = 1'b0;
    if (!ctrl_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_evt) begin
            state_d = WAIT_SYNC;
            clr_sat = 1'b1;
          end
        end
        WAIT_SYNC: begin
          if (sync_in) begin
            state_d = ACCUM;
            len_d   = len_req;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
      // Continuous mode re-latches L so the next sample starts a new window gaplessly.
      if (accept) begin
        if (smp_last) begin
          cnt_d = '0;
          if (ctrl_cont) len_d   = len_req;
          else           state_d = IDLE;
        end else begin
          cnt_d = cnt_eff + CW'(1);
        end
      end
    end
  end

  sum_sq_accum #(
    .ADC_W (ADC_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk_i      (user_clk),
    .rst_ni     (user_rst_n),
    .adc_data_i (adc_data),
    .smp_vld_i  (accept),
    .smp_last_i (smp_last),
    .flush_i    (~ctrl_en),
    .clr_sat_i  (clr_sat),
    .sum_o      (sum_sq_out),
    .sum_vld_o  (sum_sq_valid),
    .win_cnt_o  (win_cnt),
    .sat_o      (sat_flag),
    .vld_p1_o   (vld_p1)
  );

  // A single-shot window's final sample is still in flight after the FSM returns to IDLE.
  assign busy = (state_q != IDLE) | vld_p1;

endmodule

// File: tb/tb_adc_sum_sq_ctrl.sv
// Directed bench for adc_sum_sq_ctrl; the accumulator is narrowed to 16 bits so
// saturation is reachable within a short window.
module tb_adc_sum_sq_ctrl;

  localparam int ADC_W = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 16;

  logic                    user_clk = 1'b0;
  logic                    user_rst_n;
  logic signed [ADC_W-1:0] adc_data;
  logic                    adc_valid;
  logic                    sync_in;
  logic                    ctrl_en;
  logic                    ctrl_arm;
  logic                    ctrl_cont;
  logic [4:0]              ctrl_len_log2;
  logic [ACC_W-1:0]        sum_sq_out;
  logic                    sum_sq_valid;
  logic [CNT_W-1:0]        win_cnt;
  logic                    sat_flag;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int exp_win = 0;

  adc_sum_sq_ctrl #(
    .ADC_W   (ADC_W),
    .ACC_W   (ACC_W),
    .LEN_MAX (24),
    .CNT_W   (CNT_W)
  ) dut (
    .user_clk      (user_clk),
    .user_rst_n    (user_rst_n),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .sync_in       (sync_in),
    .ctrl_en       (ctrl_en),
    .ctrl_arm      (ctrl_arm),
    .ctrl_cont     (ctrl_cont),
    .ctrl_len_log2 (ctrl_len_log2),
    .sum_sq_out    (sum_sq_out),
    .sum_sq_valid  (sum_sq_valid),
    .win_cnt       (win_cnt),
    .sat_flag      (sat_flag),
    .busy          (busy)
  );

  always #5 user_clk = ~user_clk;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [7:0] d, input logic s);
    adc_valid = v;
    adc_data  = d;
    sync_in   = s;
  endtask

  task automatic arm_pulse();
    ctrl_arm = 1'b1;
    tick();
    ctrl_arm = 1'b0;
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0;
    ctrl_en = 1'b0; ctrl_arm = 1'b0; ctrl_cont = 1'b0; ctrl_len_log2 = 5'd0;
    drive(1'b0, 8'sd0, 1'b0);
    #2;
    checks++;
    if ({sum_sq_out, sum_sq_valid, win_cnt, sat_flag, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sum=%0d vld=%b win=%0d sat=%b busy=%b, required all 0",
               sum_sq_out, sum_sq_valid, win_cnt, sat_flag, busy);
    end
    @(negedge user_clk);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    ctrl_en = 1'b1; ctrl_cont = 1'b0; ctrl_len_log2 = 5'd2;
    tick();
    arm_pulse();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_wait_busy: busy=%b required 1", busy);
    end
    drive(1'b1, 8'sd1, 1'b1);    tick();
    drive(1'b1, -8'sd2, 1'b0);   tick();
    drive(1'b1, 8'sd3, 1'b0);    tick();
    drive(1'b1, -8'sd128, 1'b0); tick();
    drive(1'b0, 8'sd0, 1'b0);
    checks++;
    if (sum_sq_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_early: vld=%b busy=%b required vld=0 busy=1", sum_sq_valid, busy);
    end
    tick();
    exp_win++;
    checks++;
    if (sum_sq_valid !== 1'b1 || sum_sq_out !== 16'd16398 || win_cnt !== 16'(exp_win)) begin
      errors++;
      $display("FAIL single_publish: vld=%b sum=%0d win=%0d required vld=1 sum=16398 win=%0d",
               sum_sq_valid, sum_sq_out, win_cnt, exp_win);
    end
    tick();
    checks++;
    if (sum_sq_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after: vld=%b busy=%b required 0 0", sum_sq_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] smp [6];
    logic [15:0]       vals [3];
    smp  = '{8'sd2, 8'sd2, 8'sd3, 8'sd3, -8'sd1, -8'sd1};
    vals = '{16'd8, 16'd18, 16'd2};
    ctrl_cont = 1'b1; ctrl_len_log2 = 5'd1;
    arm_pulse();
    for (int k = 0; k < 9; k++) begin
      if (k < 6) drive(1'b1, smp[k], k == 0);
      else       drive(1'b0, 8'sd0, 1'b0);
      tick();
      checks++;
      if (k == 2 || k == 4 || k == 6) begin
        exp_win++;
        if (sum_sq_valid !== 1'b1 || sum_sq_out !== vals[(k-2)/2] || win_cnt !== 16'(exp_win)) begin
          errors++;
          $display("FAIL cont_publish_%0d: vld=%b sum=%0d win=%0d required vld=1 sum=%0d win=%0d",
                   k, sum_sq_valid, sum_sq_out, win_cnt, vals[(k-2)/2], exp_win);
        end
      end else if (sum_sq_valid !== 1'b0) begin
        errors++; $display("FAIL cont_nostrobe_%0d: vld=%b required 0", k, sum_sq_valid);
      end
    end
    ctrl_en = 1'b0; tick();
    ctrl_en = 1'b1; ctrl_cont = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cont_stop_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_valid_gaps();
    logic              v [7];
    logic signed [7:0] d [7];
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    d = '{8'sd5, 8'sd0, 8'sd0, -8'sd5, 8'sd0, 8'sd1, 8'sd1};
    ctrl_len_log2 = 5'd2;
    arm_pulse();
    for (int k = 0; k < 10; k++) begin
      if (k < 7) drive(v[k], d[k], k == 0);
      else       drive(1'b0, 8'sd0, 1'b0);
      tick();
      checks++;
      if (k == 7) begin
        exp_win++;
        if (sum_sq_valid !== 1'b1 || sum_sq_out !== 16'd52 || win_cnt !== 16'(exp_win)) begin
          errors++;
          $display("FAIL gaps_publish: vld=%b sum=%0d win=%0d required vld=1 sum=52 win=%0d",
                   sum_sq_valid, sum_sq_out, win_cnt, exp_win);
        end
      end else if (sum_sq_valid !== 1'b0) begin
        errors++; $display("FAIL gaps_nostrobe_%0d: vld=%b required 0", k, sum_sq_valid);
      end
    end
  endtask

  task automatic test_saturation();
    ctrl_len_log2 = 5'd3;
    arm_pulse();
    for (int k = 0; k < 10; k++) begin
      drive(k < 8, -8'sd128, k == 0);
      tick();
      if (k == 8) begin
        exp_win++;
        checks++;
        if (sum_sq_valid !== 1'b1 || sum_sq_out !== 16'hFFFF || sat_flag !== 1'b1) begin
          errors++;
          $display("FAIL sat_publish: vld=%b sum=%h sat=%b required vld=1 sum=ffff sat=1",
                   sum_sq_valid, sum_sq_out, sat_flag);
        end
      end
    end
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_sticky: sat=%b required 1", sat_flag);
    end
    arm_pulse();
    checks++;
    if (sat_flag !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sat_clear_on_arm: sat=%b busy=%b required sat=0 busy=1", sat_flag, busy);
    end
    ctrl_en = 1'b0; tick();
    ctrl_en = 1'b1;
  endtask

  task automatic test_abort();
    int strobes;
    ctrl_len_log2 = 5'd3;
    arm_pulse();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'sd10, k == 0);
      tick();
    end
    ctrl_en = 1'b0;
    drive(1'b1, 8'sd10, 1'b0);
    tick();
    ctrl_en = 1'b1;
    drive(1'b0, 8'sd0, 1'b0);
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      if (sum_sq_valid === 1'b1) strobes++;
      tick();
    end
    checks++;
    if (strobes != 0 || sum_sq_out !== 16'hFFFF || win_cnt !== 16'(exp_win) || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: strobes=%0d sum=%h win=%0d busy=%b required 0 ffff %0d 0",
               strobes, sum_sq_out, win_cnt, busy, exp_win);
    end
    arm_pulse();
    for (int k = 0; k < 10; k++) begin
      drive(k < 8, 8'(k + 1), k == 0);
      tick();
      if (k == 8) begin
        exp_win++;
        checks++;
        if (sum_sq_valid !== 1'b1 || sum_sq_out !== 16'd204 || win_cnt !== 16'(exp_win) || sat_flag !== 1'b0) begin
          errors++;
          $display("FAIL abort_rerun: vld=%b sum=%0d win=%0d sat=%b required 1 204 %0d 0",
                   sum_sq_valid, sum_sq_out, win_cnt, sat_flag, exp_win);
        end
      end
    end
  endtask

  task automatic test_ignored_events();
    int strobes;
    ctrl_len_log2 = 5'd2;
    drive(1'b1, 8'sd7, 1'b1);
    tick();
    drive(1'b0, 8'sd0, 1'b0);
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      if (busy === 1'b1 || sum_sq_valid === 1'b1) strobes++;
      tick();
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL sync_before_arm: active_cycles=%0d required 0", strobes);
    end
    arm_pulse();
    drive(1'b1, 8'sd2, 1'b1); tick();
    ctrl_arm = 1'b1;
    drive(1'b1, 8'sd2, 1'b0); tick();
    ctrl_arm = 1'b0;
    drive(1'b1, 8'sd2, 1'b0); tick();
    drive(1'b1, 8'sd2, 1'b0); tick();
    drive(1'b0, 8'sd0, 1'b0); tick();
    exp_win++;
    checks++;
    if (sum_sq_valid !== 1'b1 || sum_sq_out !== 16'd16 || win_cnt !== 16'(exp_win)) begin
      errors++;
      $display("FAIL arm_in_accum: vld=%b sum=%0d win=%0d required vld=1 sum=16 win=%0d",
               sum_sq_valid, sum_sq_out, win_cnt, exp_win);
    end
  endtask

  task automatic test_reset_mid_window();
    int strobes;
    ctrl_len_log2 = 5'd3;
    arm_pulse();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'sd9, k == 0);
      tick();
    end
    #3;
    user_rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_sq_out, sum_sq_valid, win_cnt, sat_flag, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_window: sum=%0d vld=%b win=%0d sat=%b busy=%b required all 0",
               sum_sq_out, sum_sq_valid, win_cnt, sat_flag, busy);
    end
    drive(1'b0, 8'sd0, 1'b0);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sum_sq_valid === 1'b1 || busy === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || win_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_release: active_cycles=%0d win=%0d required 0 0", strobes, win_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_back_to_back();
    test_valid_gaps();
    test_saturation();
    test_abort();
    test_ignored_events();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sum_sq_ctrl.md
Name: adc_sum_sq_ctrl

Overview:
- Sequences the ADC power (sum-of-squares) measurement in the user clock domain.
- Squares each valid ADC sample and accumulates it over a window of 2^L valid samples. The window is software-selected and is started by an arm command plus an external sync pulse.
- At window end it publishes a saturated 32-bit total and a window counter. Both feed the existing simulink-to-PPC software registers (user_data_in) read over OPB.
- Supports single-shot and gapless continuous operation.

Parameters:
- ADC_W, 8, signed ADC sample width (two's complement).
- ACC_W, 32, accumulator and published result width.
- LEN_MAX, 24, maximum log2 window length. Requested values above this are clamped to it.
- CNT_W, 16, published window-counter width.

Ports:
- user_clk  in  1  sole clock
- user_rst_n  in  1  asynchronous active-low reset
- adc_data  in  ADC_W  signed sample
- adc_valid  in  1  sample qualifier
- sync_in  in  1  single-cycle external sync pulse
- ctrl_en  in  1  level enable from software register
- ctrl_arm  in  1  rising-edge-detected arm command from software register
- ctrl_cont  in  1  1 = continuous, 0 = single-shot
- ctrl_len_log2  in  5  window length L; window = 2^min(L,LEN_MAX) valid samples
- sum_sq_out  out  ACC_W  last published sum of squares
- sum_sq_valid  out  1  one-cycle publish strobe
- win_cnt  out  CNT_W  count of published windows, wraps modulo 2^CNT_W
- sat_flag  out  1  sticky: some published window saturated
- busy  out  1  high in WAIT_SYNC or ACCUM, or while the pipeline holds window data

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - FSM in IDLE; pipeline and accumulator cleared.
- ctrl_arm edge detection: internal register of previous ctrl_arm; arm event = ctrl_arm & ~prev.
- FSM states and transitions:
  - IDLE: on arm event with ctrl_en=1, go to WAIT_SYNC and clear sat_flag.
  - WAIT_SYNC: on sync_in=1, go to ACCUM. The sample present in that same cycle, if valid, is the first sample of the window.
  - ACCUM: on accepting the 2^L-th valid sample, tag that sample "last".
    - ctrl_cont=1: stay in ACCUM. The next valid sample (even in the next cycle) starts a new window; windows are gapless.
    - ctrl_cont=0: go to IDLE.
- L is latched when ACCUM is entered and again at each continuous-window restart. Changing ctrl_len_log2 mid-window has no effect on the current window.
- Pipeline:
  - Stage 1 registers sq = adc_data*adc_data (unsigned, 2*ADC_W-1 bits), sq_v and last.
  - Stage 2:
    - If sq_v and not last: acc <= sat(acc+sq).
    - If sq_v and last: sum_sq_out <= sat(acc+sq), sum_sq_valid <= 1, win_cnt++, acc <= 0, sat_flag |= saturated.
- Latency: sum_sq_valid asserts 2 cycles after the last sample is presented.
- Saturation: the sum clamps at 2^ACC_W-1 and stays there for the rest of the window.
- Width rule: -128 squared = 16384 is exact; there is no truncation before accumulation.
- adc_valid=0 cycles are not counted and add nothing.
- Window counter is LEN_MAX+1 bits. Terminal count = 2^L; L=0 means 1 sample per window.
- sync_in outside WAIT_SYNC is ignored. An arm event outside IDLE is ignored.
- ctrl_en=0 in any state: next cycle go to IDLE and flush stage 1 and the accumulator. There is no publish for the partial window. sum_sq_out and win_cnt retain their values.
- The pipeline drains after single-shot completion even though the FSM is already in IDLE. busy stays high until the publish cycle.
- Async reset mid-window: everything cleared immediately; no publish.

Decomposition:
- Shared package adc_sum_sq_pkg holds:
  - state enum {IDLE, WAIT_SYNC, ACCUM};
  - sat_add function;
  - default widths ADC_W, ACC_W, LEN_MAX, CNT_W.
- One natural sub-module: sum_sq_accum. It contains the two pipeline stages (square register, saturating accumulator, publish logic) and is driven by valid/last from the FSM top.

Test Plan:
- Single-shot, L=2, arm then sync, samples 1,-2,3,-128 on consecutive cycles:
  - sum_sq_valid exactly 2 cycles after the -128 sample;
  - sum_sq_out=16398, win_cnt=1, FSM IDLE, busy drops after the strobe.
- Continuous, L=1, samples 2,2,3,3,-1,-1 every cycle:
  - publishes 8, 18, 2 on back-to-back windows with no dropped samples;
  - win_cnt increments to 3.
- Valid gaps, L=2, samples 5,x,x,-5,x,1,1 (x = adc_valid 0):
  - single publish of 52, 2 cycles after the final 1.
- Saturation, L=20, all samples -128:
  - sum_sq_out=0xFFFFFFFF, sat_flag=1;
  - a subsequent arm clears sat_flag to 0 at WAIT_SYNC entry.
- Abort: ctrl_en dropped after 3 of 8 samples (L=3):
  - no strobe; sum_sq_out and win_cnt unchanged;
  - re-enable, arm, sync then gives a clean full-window result.
- Reset and ignored events:
  - assert user_rst_n=0 mid-window: all outputs 0 immediately.
  - sync_in before arm is ignored (FSM stays IDLE).
  - arm during ACCUM is ignored.
